// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - half-period note classifier with lock hysteresis and silence timeout
// Optional GLITCH_FILTER_EN adds an 8-cycle stability filter after the synchroniser.
module tone_detector #(
   parameter int CNT_W   = 15,
   parameter int HP0     = 13515,
   parameter int HP1     = 11364,
   parameter int HP2     = 9021,
   parameter int HP3     = 7585,
   parameter int TOL     = 64,
   parameter int CONFIRM = 4,
   parameter int TIMEOUT = 20000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       AUDIO_IN,
   output logic [1:0] NOTE,
   output logic       VALID,
   output logic       NOTE_STRB
);

   localparam int MC_W = $clog2(CONFIRM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   logic             sync1, sync2, lvl, lvl_d, edge_p;
   logic [CNT_W-1:0] per_cnt;
   logic             hit;
   logic [1:0]       hit_note;

   state_t           state, state_n;
   logic [1:0]       cand, cand_n;
   logic             cand_v, cand_v_n;
   logic [MC_W-1:0]  mcnt, mcnt_n;
   logic [1:0]       note_n;
   logic             valid_n, strb_n;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= AUDIO_IN;
         sync2 <= sync1;
      end
   end

`ifdef GLITCH_FILTER_EN
   logic [2:0] stab_cnt;
   logic       filt;

   // New level is taken only after sync2 has disagreed with it for 8 straight cycles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stab_cnt <= 3'd0;
         filt     <= 1'b0;
      end else if (sync2 == filt) begin
         stab_cnt <= 3'd0;
      end else if (stab_cnt == 3'd7) begin
         stab_cnt <= 3'd0;
         filt     <= sync2;
      end else begin
         stab_cnt <= stab_cnt + 3'd1;
      end
   end

   assign lvl = filt;
`else
   assign lvl = sync2;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lvl_d  <= 1'b0;
         edge_p <= 1'b0;
      end else begin
         lvl_d  <= lvl;
         edge_p <= lvl ^ lvl_d;
      end
   end

   // per_cnt holds the cycles since the last edge pulse, so on an edge it equals M.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         per_cnt <= '0;
      end else if (edge_p) begin
         per_cnt <= CNT_W'(1);
      end else if (per_cnt != CNT_MAX) begin
         per_cnt <= per_cnt + CNT_W'(1);
      end
   end

   function automatic logic in_win(input logic [CNT_W-1:0] m, input int hp);
      logic [31:0] m32;
      m32 = 32'(m);
      return (m32 + 32'(TOL) >= 32'(hp)) && (m32 <= 32'(hp + TOL));
   endfunction

   always_comb begin
      hit      = 1'b1;
      hit_note = 2'd0;
      if (in_win(per_cnt, HP0))      hit_note = 2'd0;
      else if (in_win(per_cnt, HP1)) hit_note = 2'd1;
      else if (in_win(per_cnt, HP2)) hit_note = 2'd2;
      else if (in_win(per_cnt, HP3)) hit_note = 2'd3;
      else                           hit      = 1'b0;
   end

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      cand_v_n = cand_v;
      mcnt_n   = mcnt;
      note_n   = NOTE;
      valid_n  = VALID;
      strb_n   = 1'b0;
      if (edge_p) begin
         case (state)
            IDLE: begin
               state_n  = ACQUIRE;
               cand_v_n = 1'b0;
               mcnt_n   = '0;
            end
            ACQUIRE: begin
               if (hit && cand_v && hit_note == cand) begin
                  mcnt_n = mcnt + MC_W'(1);
               end else if (hit) begin
                  cand_n   = hit_note;
                  cand_v_n = 1'b1;
                  mcnt_n   = MC_W'(1);
               end else begin
                  cand_v_n = 1'b0;
                  mcnt_n   = '0;
               end
               if (hit && mcnt_n >= MC_W'(CONFIRM)) begin
                  state_n = LOCKED;
                  valid_n = 1'b1;
                  note_n  = cand_n;
                  strb_n  = 1'b1;
               end
            end
            LOCKED: begin
               if (!(hit && hit_note == cand)) begin
                  state_n  = ACQUIRE;
                  valid_n  = 1'b0;
                  cand_n   = hit ? hit_note : cand;
                  cand_v_n = hit;
                  mcnt_n   = hit ? MC_W'(1) : '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (per_cnt >= CNT_W'(TIMEOUT)) begin
         // An edge in the same cycle takes priority over the silence timeout.
         state_n  = IDLE;
         valid_n  = 1'b0;
         cand_v_n = 1'b0;
         mcnt_n   = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cand      <= 2'd0;
         cand_v    <= 1'b0;
         mcnt      <= '0;
         NOTE      <= 2'd0;
         VALID     <= 1'b0;
         NOTE_STRB <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cand_v    <= cand_v_n;
         mcnt      <= mcnt_n;
         NOTE      <= note_n;
         VALID     <= valid_n;
         NOTE_STRB <= strb_n;
      end
   end

endmodule

// File: tb/tb_tone_detector.sv
// tb/tb_tone_detector.sv - scoreboard bench for tone_detector with scaled half-periods
module tb_tone_detector;

   localparam int HP0 = 540, HP1 = 450, HP2 = 360, HP3 = 300;
   localparam int TOL = 8, CONFIRM = 4, TIMEOUT = 800, CNT_W = 10;
`ifdef GLITCH_FILTER_EN
   localparam int D = 12;
`else
   localparam int D = 4;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       AUDIO_IN = 1'b0;
   logic [1:0] NOTE;
   logic       VALID, NOTE_STRB;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int         c;
      logic       v;
      logic [1:0] n;
      logic       s;
   } ev_t;
   ev_t expq[$];

   tone_detector #(
      .CNT_W(CNT_W), .HP0(HP0), .HP1(HP1), .HP2(HP2), .HP3(HP3),
      .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK), .RST(RST), .AUDIO_IN(AUDIO_IN),
      .NOTE(NOTE), .VALID(VALID), .NOTE_STRB(NOTE_STRB)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic push(input int c, input logic v, input logic [1:0] n, input logic s);
      ev_t e;
      e.c = c; e.v = v; e.n = n; e.s = s;
      expq.push_back(e);
   endtask

   task automatic half(input int hp);
      repeat (hp) @(posedge CLK);
      #2 AUDIO_IN = ~AUDIO_IN;
   endtask

   task automatic halves(input int k, input int hp);
      for (int i = 0; i < k; i++) half(hp);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: every VALID change or NOTE_STRB pulse must match the next queued expectation.
   initial begin
      logic pv;
      ev_t  e;
      pv = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            pv = VALID;
         end else if (VALID !== pv || NOTE_STRB !== 1'b0) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: cycle %0d VALID=%b NOTE=%0d STRB=%b, required no event",
                        cyc, VALID, NOTE, NOTE_STRB);
            end else begin
               e = expq.pop_front();
               if (cyc != e.c || VALID !== e.v || NOTE !== e.n || NOTE_STRB !== e.s) begin
                  errors++;
                  $display("FAIL event: got cycle %0d VALID=%b NOTE=%0d STRB=%b, required cycle %0d VALID=%b NOTE=%0d STRB=%b",
                           cyc, VALID, NOTE, NOTE_STRB, e.c, e.v, e.n, e.s);
               end
            end
            pv = VALID;
         end
      end
   end

   initial begin
      #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_valid", 32'(VALID), 0);
      check("reset_note", 32'(NOTE), 0);
      check("reset_strb", 32'(NOTE_STRB), 0);
      @(posedge CLK);
      #2 RST = 1'b0;

      // Lock on note 1 at the 5th edge, then hold for 20 more half-periods.
      halves(4, HP1);
      push(cyc + HP1 + D, 1'b1, 2'd1, 1'b1);
      half(HP1);
      halves(20, HP1);
      check("lock_hold_valid", 32'(VALID), 1);
      check("lock_hold_note", 32'(NOTE), 1);

      // Asynchronous reset while locked.
      @(posedge CLK);
      #2 RST = 1'b1;
      AUDIO_IN = 1'b0;
      #1;
      check("async_rst_valid", 32'(VALID), 0);
      check("async_rst_note", 32'(NOTE), 0);
      check("async_rst_strb", 32'(NOTE_STRB), 0);
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      halves(4, HP1);
      push(cyc + HP1 + D, 1'b1, 2'd1, 1'b1);
      half(HP1);

      // Note change 1 -> 0 -> 2; NOTE holds while VALID is low.
      push(cyc + HP0 + D, 1'b0, 2'd1, 1'b0);
      half(HP0);
      halves(2, HP0);
      push(cyc + HP0 + D, 1'b1, 2'd0, 1'b1);
      half(HP0);
      halves(2, HP0);
      push(cyc + HP2 + D, 1'b0, 2'd0, 1'b0);
      half(HP2);
      halves(2, HP2);
      push(cyc + HP2 + D, 1'b1, 2'd2, 1'b1);
      half(HP2);

      // Tolerance edges around note 3.
      push(cyc + HP3 + TOL + D, 1'b0, 2'd2, 1'b0);
      half(HP3 + TOL);
      halves(2, HP3 + TOL);
      push(cyc + HP3 + TOL + D, 1'b1, 2'd3, 1'b1);
      half(HP3 + TOL);
      push(cyc + HP3 + TOL + 1 + D, 1'b0, 2'd3, 1'b0);
      half(HP3 + TOL + 1);
      halves(10, HP3 + TOL + 1);
      check("tol_over_valid", 32'(VALID), 0);
      halves(3, HP3 - TOL);
      push(cyc + HP3 - TOL + D, 1'b1, 2'd3, 1'b1);
      half(HP3 - TOL);
      push(cyc + HP3 - TOL - 1 + D, 1'b0, 2'd3, 1'b0);
      half(HP3 - TOL - 1);
      halves(6, HP3 - TOL - 1);
      check("tol_under_valid", 32'(VALID), 0);

      // Silence timeout from LOCKED, then relock from IDLE needs 5 edges.
      halves(3, HP0);
      push(cyc + HP0 + D, 1'b1, 2'd0, 1'b1);
      half(HP0);
      push(cyc + TIMEOUT + D, 1'b0, 2'd0, 1'b0);
      repeat (TIMEOUT + 400) @(posedge CLK);
      #2;
      check("silence_valid", 32'(VALID), 0);
      halves(4, HP0);
      push(cyc + HP0 + D, 1'b1, 2'd0, 1'b1);
      half(HP0);

      // Edge landing on the timeout cycle is measured, so only 4 more edges relock.
      push(cyc + TIMEOUT + D, 1'b0, 2'd0, 1'b0);
      half(TIMEOUT);
      halves(3, HP0);
      push(cyc + HP0 + D, 1'b1, 2'd0, 1'b1);
      half(HP0);

      // Lock note 2, then inject a 3-cycle glitch mid half-period.
      push(cyc + HP2 + D, 1'b0, 2'd0, 1'b0);
      half(HP2);
      halves(2, HP2);
      push(cyc + HP2 + D, 1'b1, 2'd2, 1'b1);
      half(HP2);
      half(150);
`ifndef GLITCH_FILTER_EN
      push(cyc + D, 1'b0, 2'd2, 1'b0);
`endif
      half(3);
      half(HP2 - 153);
      halves(3, HP2);
`ifndef GLITCH_FILTER_EN
      push(cyc + HP2 + D, 1'b1, 2'd2, 1'b1);
`endif
      half(HP2);
      halves(3, HP2);
      check("glitch_end_valid", 32'(VALID), 1);
      check("glitch_end_note", 32'(NOTE), 2);

      repeat (D + 20) @(posedge CLK);
      #2;
      check("pending_events", 32'(expq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
